// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions: FSM state type, magnitude width helper
// and zero-sign normalisation.
package sm_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADJ  = 2'd2
  } sm_state_e;

  // Magnitude width of a WIDTH-bit sign-magnitude operand.
  function automatic int mag_w(input int width);
    return width - 1;
  endfunction

  // A zero magnitude always carries a positive sign.
  function automatic logic sm_norm_zero(input logic sign, input logic mag_is_zero);
    return sign & ~mag_is_zero;
  endfunction

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude adder: same signs add, different signs subtract the
// smaller magnitude from the larger and keep the larger one's sign. Zero is +0.
module sm_addsub
  import sm_arith_pkg::*;
#(
  parameter int MAG_W = 14
) (
  input  logic             i_sign_a,
  input  logic [MAG_W-1:0] i_mag_a,
  input  logic             i_sign_b,
  input  logic [MAG_W-1:0] i_mag_b,
  output logic             o_sign,
  output logic [MAG_W-1:0] o_mag
);

  logic w_sign_raw;

  // Magnitude/sign selection for the three sign-magnitude add cases.
  always_comb begin
    w_sign_raw = 1'b0;
    o_mag      = '0;
    if (i_sign_a == i_sign_b) begin
      o_mag      = i_mag_a + i_mag_b;
      w_sign_raw = i_sign_a;
    end else if (i_mag_a >= i_mag_b) begin
      o_mag      = i_mag_a - i_mag_b;
      w_sign_raw = i_sign_a;
    end else begin
      o_mag      = i_mag_b - i_mag_a;
      w_sign_raw = i_sign_b;
    end
  end

  assign o_sign = sm_norm_zero(w_sign_raw, (o_mag == '0));

endmodule

// File: rtl/sm_multiplier_seq.sv
// Sequential sign-magnitude shift-add multiplier, one magnitude bit per cycle.
// Optional addend stage (z = x*y + a) enabled by defining SM_MUL_ADDEND_EN.
module sm_multiplier_seq
  import sm_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef SM_MUL_ADDEND_EN
  input  logic [WIDTH-1:0]   a,
`endif
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  localparam int MW = mag_w(WIDTH);
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(WIDTH);

  sm_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_mcand;
  logic [MW-1:0]   r_acc;
  logic [MW-1:0]   r_mplier;
  logic            r_sign;
  logic [2*WIDTH-1:0] r_z;
  logic            r_busy;
  logic            r_done;

  logic [MW:0]     w_sum;
  logic [MW-1:0]   w_acc_nx;
  logic [MW-1:0]   w_mpl_nx;
  logic [PW-1:0]   w_prod;
  logic            w_last;

  // Conditional add into the upper half, then shift {carry, acc, mplier} right.
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_mcand & {MW{r_mplier[0]}}};
  assign w_acc_nx = w_sum[MW:1];
  assign w_mpl_nx = {w_sum[0], r_mplier[MW-1:1]};
  assign w_prod   = {w_acc_nx, w_mpl_nx};
  assign w_last   = (r_cnt == CW'(WIDTH - 2));

`ifdef SM_MUL_ADDEND_EN
  logic            r_a_sign;
  logic [MW-1:0]   r_a_mag;
  logic            w_adj_sign;
  logic [PW-1:0]   w_adj_mag;

  sm_addsub #(.MAG_W(PW)) u_addsub (
    .i_sign_a (r_sign),
    .i_mag_a  ({r_acc, r_mplier}),
    .i_sign_b (r_a_sign),
    .i_mag_b  ({{MW{1'b0}}, r_a_mag}),
    .o_sign   (w_adj_sign),
    .o_mag    (w_adj_mag)
  );
`endif

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_z      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SM_MUL_ADDEND_EN
      r_a_sign <= 1'b0;
      r_a_mag  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= x[MW-1:0];
            r_mplier <= y[MW-1:0];
            r_sign   <= x[WIDTH-1] ^ y[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
`ifdef SM_MUL_ADDEND_EN
            r_a_sign <= a[WIDTH-1];
            r_a_mag  <= a[MW-1:0];
`endif
          end
        end
        RUN: begin
          r_acc    <= w_acc_nx;
          r_mplier <= w_mpl_nx;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
`ifdef SM_MUL_ADDEND_EN
            r_state <= ADJ;
`else
            r_z     <= {sm_norm_zero(r_sign, (w_prod == '0)), 1'b0, w_prod};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
`endif
          end
        end
`ifdef SM_MUL_ADDEND_EN
        ADJ: begin
          r_z     <= {w_adj_sign, 1'b0, w_adj_mag};
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign z    = r_z;
  assign busy = r_busy;
  assign done = r_done;

endmodule
